// File: rtl/w_rom_fetch_seq.sv
// Weight ROM fetch sequencer: issues a run of wrapping ROM reads and streams the
// returned words through a 2-entry buffer as a valid/ready stream.
module w_rom_fetch_seq #(
    parameter int  DATA_WIDTH = 4806,
    parameter int  DATA_DEPTH = 512,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_cen_b,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         num_q, issued_q, accepted_q;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  issue, pop;

    assign w_valid   = (count != 2'd0);
    assign w_data    = buf_mem[rd_ptr];
    assign pop       = w_valid & w_ready;
    assign w_last    = w_valid && (accepted_q == num_q - CW'(1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rom_cen_b = ~issue;
    // DATA_DEPTH is a power of two, so the ADDR_WIDTH add wraps modulo depth.
    assign rom_addr  = base_q + issued_q[ADDR_WIDTH-1:0];
    // Slots committed after this edge; a pop this cycle frees one.
    assign occ       = 3'(count) + 3'(in_flight) - 3'(pop);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = (num_words == '0) ? S_DONE : S_FETCH;
            S_FETCH: begin
                issue = (occ < 3'd2);
                if (issue && (issued_q + CW'(1) == num_q)) state_nx = S_DRAIN;
            end
            S_DRAIN: if (pop && w_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            in_flight  <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            state     <= state_nx;
            in_flight <= issue;
            if (state == S_IDLE && start) begin
                base_q     <= base_addr;
                num_q      <= num_words;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (issue) issued_q <= issued_q + CW'(1);
                if (pop)   accepted_q <= accepted_q + CW'(1);
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (in_flight) begin
                buf_mem[wr_ptr] <= rom_q;
                wr_ptr          <= ~wr_ptr;
            end
            count <= count + 2'(in_flight) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_w_rom_fetch_seq.sv
// Randomized bench for w_rom_fetch_seq: ROM model, command driver and a
// scoreboard monitor that derives expected words, addresses and timing.
module tb_w_rom_fetch_seq;
    localparam int DW = 4806;
    localparam int DEPTH = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy, done, rom_cen_b, w_valid, w_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q = '0;
    logic [DW-1:0] w_data;
    logic          w_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    w_rom_fetch_seq #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .rom_cen_b(rom_cen_b),
        .rom_addr(rom_addr), .rom_q(rom_q), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_last(w_last)
    );

    always #5 clk = ~clk;

    // ROM bank model: registered read, one cycle latency.
    logic [DW-1:0] rom [DEPTH];
    always @(posedge clk) if (!rom_cen_b) rom_q <= rom[rom_addr];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    bit            mdl_busy = 0, exp_done = 0, prev_rst = 0, seen_valid = 0, rdy_all = 0;
    bit            stall_prev = 0, nx_busy, nx_done;
    logic [DW-1:0] stall_data;
    logic [DW:0]   e;
    logic [AW-1:0] a;
    int            cyc = 0, t_start = 0, cur_n = 0, out_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete(); addr_q.delete();
            mdl_busy = 0; exp_done = 0; out_cnt = 0; stall_prev = 0; prev_rst = 1;
        end else begin
            nx_busy = mdl_busy;
            nx_done = 0;
            chk("busy", busy, mdl_busy);
            if (prev_rst) chk("valid_after_rst", w_valid, 0);
            if (done || exp_done) begin
                chk("done", done, exp_done);
                if (exp_done) begin
                    nx_busy = 0;
                    if (rdy_all && cur_n > 0) chk("done_cycle", cyc - t_start, cur_n + 3);
                end
            end
            if (!mdl_busy) chk("cen_idle", rom_cen_b, 1);
            if (!rom_cen_b) begin
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_read act=addr %0d exp=no read", rom_addr);
                end else begin
                    a = addr_q.pop_front();
                    chk("rom_addr", rom_addr, a);
                end
            end
            if (stall_prev) begin
                chk("stall_valid", w_valid, 1);
                chk("stall_data", w_data == stall_data, 1);
            end
            stall_prev = w_valid && !w_ready;
            stall_data = w_data;
            if (w_valid && !seen_valid && mdl_busy) begin
                seen_valid = 1;
                chk("first_latency", cyc - t_start, 3);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_word act=%h exp=none", w_data[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (w_data != e[DW-1:0]) begin
                        errors++;
                        $display("FAIL w_data act=%h exp=%h (low 64 bits)", w_data[63:0], e[63:0]);
                    end
                    chk("w_last", w_last, e[DW]);
                    if (e[DW]) nx_done = 1;
                end
            end
            out_cnt += int'(!rom_cen_b) - int'(w_valid && w_ready);
            chk("fifo_occ_le2", out_cnt <= 2, 1);
            if (!w_ready && mdl_busy) rdy_all = 0;
            if (start && !mdl_busy) begin
                t_start = cyc; cur_n = int'(num_words);
                seen_valid = 0; rdy_all = 1; nx_busy = 1;
                for (int i = 0; i < cur_n; i++) begin
                    addr_q.push_back(AW'((int'(base_addr) + i) % DEPTH));
                    exp_q.push_back({(i == cur_n - 1), rom[(int'(base_addr) + i) % DEPTH]});
                end
                if (cur_n == 0) nx_done = 1;
            end
            mdl_busy = nx_busy;
            exp_done = nx_done;
            prev_rst = 0;
        end
    end

    // mode 0: w_ready high; mode 1: random w_ready with a 10-cycle stall.
    task automatic run_cmd(input int b, input int n, input int mode, input int ign_at, input int rst_at);
        int k;
        @(posedge clk); #1;
        start = 1; base_addr = AW'(b); num_words = (AW+1)'(n); w_ready = 1;
        @(posedge clk); #1;
        start = 0; base_addr = AW'($urandom); num_words = (AW+1)'($urandom);
        k = 1;
        while (mdl_busy) begin
            start = (k == ign_at);
            if (k == ign_at) begin base_addr = 7; num_words = 3; end
            rst = (k == rst_at);
            if (mode == 0) w_ready = 1;
            else w_ready = (k >= 12 && k < 22) ? 1'b0 : 1'($urandom % 2);
            @(posedge clk); #1;
            k++;
            if (k > 3000) begin
                checks++; errors++;
                $display("FAIL cmd_timeout act=busy exp=idle");
                break;
            end
        end
        start = 0; rst = 0; w_ready = 1;
    endtask

    initial begin
        logic [151*32-1:0] tmp;
        for (int ad = 0; ad < DEPTH; ad++) begin
            for (int j = 0; j < 151; j++) tmp[j*32 +: 32] = $urandom;
            rom[ad] = tmp[DW-1:0];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cen_b", rom_cen_b, 1);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_last", w_last, 0);
        chk("rst_data_zero", w_data == '0, 1);
        #1 rst = 0;
        run_cmd(5, 1, 0, 0, 0);        // single word
        run_cmd(0, 16, 0, 5, 0);       // streaming plus ignored start
        run_cmd(510, 4, 0, 0, 0);      // wrap-around
        run_cmd(100, 8, 1, 0, 0);      // back-pressure
        run_cmd(33, 0, 0, 0, 0);       // zero length
        run_cmd(0, 16, 0, 0, 6);       // reset mid-command
        run_cmd(40, 16, 0, 0, 0);      // fresh command after reset
        run_cmd(300, 512, 0, 0, 0);    // full depth
        for (int r = 0; r < 8; r++)
            run_cmd(int'($urandom % DEPTH), int'($urandom_range(1, 40)), int'($urandom % 2), 0, 0);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/w_rom_fetch_seq.md
# w_rom_fetch_seq

Address sequencer and output buffer that sits directly downstream of the 512-deep weight ROM bank and upstream of the PE array weight port. On a `start` command it issues `num_words` consecutive ROM reads from `base_addr`, wrapping modulo `DATA_DEPTH`. It absorbs the ROM's fixed 1-cycle read latency in a 2-entry buffer and presents the words as a valid/ready stream with full back-pressure. It sustains 1 word/cycle while `w_ready` stays high, and never loses a word when `w_ready` drops.

## Interface
- `DATA_WIDTH`, 4806 — weight word width; equals the ROM bank `data_out` width.
- `DATA_DEPTH`, 512 — ROM depth in words.
- `ADDR_WIDTH`, `$clog2(DATA_DEPTH)` — ROM address width (localparam).
- `clk`  in  1  — single clock for all state.
- `rst`  in  1  — reset, synchronous, active-high.
- `start`  in  1  — one-cycle command pulse; accepted only in IDLE, ignored otherwise.
- `base_addr`  in  ADDR_WIDTH  — first ROM address; sampled with an accepted `start`.
- `num_words`  in  ADDR_WIDTH+1  — words to fetch, 0..DATA_DEPTH; sampled with an accepted `start`.
- `busy`  out  1  — high whenever state ≠ IDLE.
- `done`  out  1  — one-cycle pulse when the command completes.
- `rom_cen_b`  out  1  — ROM read enable, active-low; drives the ROM bank `r_en`.
- `rom_addr`  out  ADDR_WIDTH  — ROM address; drives the ROM bank `addr_in`.
- `rom_q`  in  DATA_WIDTH  — ROM data; valid the cycle after a read is sampled.
- `w_data`  out  DATA_WIDTH  — head-of-buffer weight word.
- `w_valid`  out  1  — `w_data` is valid.
- `w_ready`  in  1  — consumer accepts a word when `w_valid & w_ready`.
- `w_last`  out  1  — qualifies the final word of the command; meaningful only while `w_valid` is high.

## Operation
- **States.** IDLE, FETCH, DRAIN, DONE.
- **IDLE.**
  - `start` latches `base_addr` and `num_words`, clears issue and accept counters.
  - Next state is FETCH if `num_words` ≠ 0, otherwise DONE.
- **FETCH.**
  - A read issues (`rom_cen_b` = 0) when buffer count + in-flight − pop_this_cycle < 2.
  - `rom_addr` = (base + issued) mod DATA_DEPTH; `ADDR_WIDTH` arithmetic wraps naturally.
  - After the read that brings issued = `num_words`, go to DRAIN.
- **DRAIN.**
  - No reads issue; `rom_cen_b` = 1.
  - When the word with `w_last` set is accepted, go to DONE.
- **DONE.**
  - `done` = 1 for exactly one cycle, then IDLE.
  - `busy` stays high in DONE.
- **Read pipeline.**
  - One-bit in-flight flag = read issued last cycle.
  - When the flag is set, `rom_q` is written into the 2-entry FIFO at the clock edge.
  - Simultaneous write and pop in the same cycle are both honoured.
- **`w_last`.** High when `w_valid` is high and accepted_count = `num_words` − 1.
- **Full buffer.** With 2 buffered words, or 1 buffered word plus 1 in flight and no pop, no read issues. The buffer therefore never overflows; an overflow is an assertion failure in the bench.
- **`start` while busy.** Ignored; latched config is unchanged.
- **`num_words` = DATA_DEPTH.** Reads every address once, beginning at `base_addr` and wrapping past DATA_DEPTH−1 to 0.
- **Reset mid-command.**
  - Next state is IDLE; FIFO and in-flight flag are cleared.
  - ROM data returning in the following cycle is discarded.
  - No `done` pulse.
- **Reset values.** `busy` = 0, `done` = 0, `rom_cen_b` = 1, `rom_addr` = 0, `w_valid` = 0, `w_last` = 0, `w_data` = 0.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: state FETCH, `rom_cen_b` = 0, `rom_addr` = base.
- Cycle 2: `rom_q` valid; written to FIFO at the end of the cycle.
- Cycle 3: `w_valid` = 1 with the first word. Start-to-first-valid latency is 3 cycles.
- With `w_ready` held high, one word per cycle with no bubbles.
- `done` asserts the cycle after the last accept; `busy` falls the cycle after that.
- `num_words` = 0: `done` in cycle 1, `busy` low in cycle 2, no ROM reads.
- `w_ready` deasserted for N cycles: `w_valid` and `w_data` stay stable; reads stop within 1 cycle; the first word accepted after `w_ready` rises again is the next address in sequence.

## Test plan
- **Single word.** `base_addr`=5, `num_words`=1, `w_ready`=1 -> one read at addr 5; `w_valid` & `w_last` in cycle 3 with ROM[5]; `done` in cycle 4.
- **Streaming.** `base_addr`=0, `num_words`=16, `w_ready`=1 -> 16 consecutive words ROM[0..15] on cycles 3..18; `w_last` only on cycle 18; `done` on cycle 19.
- **Wrap-around.** `base_addr`=510, `num_words`=4 -> addresses 510, 511, 0, 1 in order; `w_last` on the word from address 1.
- **Back-pressure.** `num_words`=8; toggle `w_ready` randomly plus one 10-cycle stall -> all 8 words delivered in order with no drops or duplicates; FIFO count never exceeds 2; `w_data` stable while stalled.
- **Zero length and ignored start.** `num_words`=0 -> `done` in cycle 1 and `rom_cen_b` never low; a second `start` pulsed mid-command in test 2 -> ignored, output identical to test 2.
- **Reset mid-operation.** Assert `rst` at cycle 6 of a 16-word command -> next cycle `busy`=0, `w_valid`=0, `rom_cen_b`=1, no `done`; a fresh `start` then completes normally.
